moving_average_master: RTL and testbench

- Streaming moving-average filter packaged as a TinyTapeout user tile (standard tt_um pin set).
- Accepts 10-bit unsigned samples on a strobe and outputs the mean of the last N samples with an output strobe.
- N is selectable at run time as 2, 4, 8 or 16.
- Sample and result buses are split across the dedicated and bidirectional pins.

---
 rtl/moving_average_pkg.sv | 38 +++
 rtl/moving_average_core.sv | 72 +++++++
 rtl/moving_average_master.sv | 47 ++++
 tb/tb_moving_average_master.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/moving_average_pkg.sv
// Shared constants for the moving-average TinyTapeout tile: widths, window
// select encoding and uio pin positions. Optional build macro: MA_ROUND_EN.
package moving_average_pkg;

    localparam int DATA_W    = 10;
    localparam int MAX_DEPTH = 16;
    localparam int SUM_W     = 14;

    localparam logic [1:0] SEL_N2  = 2'b00;
    localparam logic [1:0] SEL_N4  = 2'b01;
    localparam logic [1:0] SEL_N8  = 2'b10;
    localparam logic [1:0] SEL_N16 = 2'b11;

    localparam int STROBE_IN_BIT  = 0;
    localparam int STROBE_OUT_BIT = 1;
    localparam int DIN_HI_LSB     = 2;
    localparam int DOUT_HI_LSB    = 4;
    localparam int SEL_LSB        = 6;

    localparam logic [7:0] UIO_OE_MASK = 8'h32;

    // log2 of the window length selected by filter_select
    function automatic logic [2:0] sel_to_shift(input logic [1:0] sel);
        logic [2:0] shift;
        case (sel)
            SEL_N2:  shift = 3'd1;
            SEL_N4:  shift = 3'd2;
            SEL_N8:  shift = 3'd3;
            default: shift = 3'd4;
        endcase
        return shift;
    endfunction

    function automatic int win_len(input logic [1:0] sel);
        return 1 << sel_to_shift(sel);
    endfunction

endpackage

// File: rtl/moving_average_core.sv
// Sample history, windowed adder and divide-by-shift. Rounds half up when
// built with MA_ROUND_EN, otherwise truncates.
module moving_average_core
    import moving_average_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    input  logic [1:0]        sel,
    output logic [DATA_W-1:0] result,
    output logic              result_valid
);

    // Handshake: sample_valid qualifies sample for one edge; there is no ready
    // because the core accepts every cycle. result_valid pulses for one cycle
    // per accepted sample and result holds until the next acceptance.

    logic [DATA_W-1:0] hist [MAX_DEPTH];
    logic [DATA_W-1:0] win  [MAX_DEPTH];
    logic [SUM_W-1:0]  sum_n;
    logic [SUM_W-1:0]  sum_adj;
    logic [2:0]        shift_amt;
    logic [DATA_W-1:0] result_d;

    // The window is the history as it will look after this edge's shift,
    // so the incoming sample is part of the average it produces.
    always_comb begin
        win[0] = sample;
        for (int i = 1; i < MAX_DEPTH; i++) begin
            win[i] = hist[i-1];
        end
    end

    always_comb begin
        sum_n = '0;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            if (i < win_len(sel)) begin
                sum_n = sum_n + SUM_W'(win[i]);
            end
        end
    end

    always_comb begin
        shift_amt = sel_to_shift(sel);
`ifdef MA_ROUND_EN
        sum_adj = sum_n + SUM_W'(win_len(sel) >> 1);
`else
        sum_adj = sum_n;
`endif
        result_d = DATA_W'(sum_adj >> shift_amt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_DEPTH; i++) begin
                hist[i] <= '0;
            end
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= sample_valid;
            if (sample_valid) begin
                for (int i = 0; i < MAX_DEPTH; i++) begin
                    hist[i] <= win[i];
                end
                result <= result_d;
            end
        end
    end

endmodule

// File: rtl/moving_average_master.sv
// TinyTapeout tile wrapper: unpacks sample/strobe/select from the pins and
// packs the averaged result back out. Optional build macro: MA_ROUND_EN.
module moving_average_master
    import moving_average_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic              sample_valid;
    logic [DATA_W-1:0] sample;
    logic [1:0]        sel;
    logic [DATA_W-1:0] result;
    logic              result_valid;
    logic              unused_bits;

    assign sample_valid = uio_in[STROBE_IN_BIT] & ena;
    assign sample       = {uio_in[DIN_HI_LSB+1:DIN_HI_LSB], ui_in};
    assign sel          = uio_in[SEL_LSB+1:SEL_LSB];
    assign unused_bits  = &{1'b0, uio_in[1], uio_in[5:4]};

    moving_average_core u_core (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample       (sample),
        .sel          (sel),
        .result       (result),
        .result_valid (result_valid)
    );

    always_comb begin
        uio_out                                = 8'h00;
        uio_out[STROBE_OUT_BIT]                = result_valid;
        uio_out[DOUT_HI_LSB+1:DOUT_HI_LSB]     = result[DATA_W-1:8];
    end

    assign uo_out = result[7:0];
    assign uio_oe = UIO_OE_MASK;

endmodule

// File: tb/tb_moving_average_master.sv
// Directed bench for moving_average_master; expected values follow the build
// (floor by default, round-half-up when MA_ROUND_EN is defined).
module tb_moving_average_master;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks = 0;
    int errors = 0;

    moving_average_master dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] get_result();
        return {uio_out[5:4], uo_out};
    endfunction

    task automatic set_pins(input logic [9:0] data, input logic [1:0] sel, input logic strobe);
        ui_in  = data[7:0];
        uio_in = {sel, 2'b00, data[9:8], 1'b0, strobe};
    endtask

    // one-cycle strobe, then check result and strobe_out, then drop strobe
    task automatic send(input logic [9:0] data, input logic [1:0] sel,
                        input logic [9:0] exp, input string tag);
        set_pins(data, sel, 1'b1);
        tick();
        check({tag, "_res"}, 16'(get_result()), 16'(exp));
        check({tag, "_stb"}, 16'(uio_out[1]), 16'd1);
        set_pins(data, sel, 1'b0);
    endtask

    initial begin
        logic [9:0] exp;
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;

        // reset state
        tick();
        check("rst_uo", 16'(uo_out), 16'h00);
        check("rst_uio", 16'(uio_out), 16'h00);
        check("rst_oe", 16'(uio_oe), 16'h32);
        rst_n = 1'b1;
        tick(); tick(); tick();
        check("idle_uo", 16'(uo_out), 16'h00);
        check("idle_uio", 16'(uio_out), 16'h00);

        // N=2 ramp, strobe every other clock
        for (int k = 0; k < 250; k++) begin
`ifdef MA_ROUND_EN
            exp = 10'(k);
`else
            exp = (k == 0) ? 10'd0 : 10'(k - 1);
`endif
            send(10'(k), 2'b00, exp, "n2_ramp");
            tick();
            check("n2_gap_stb", 16'(uio_out[1]), 16'd0);
            check("n2_hold", 16'(get_result()), 16'(exp));
        end

        // continue the ramp at N=4, 8, 16 (history stays contiguous)
        for (int k = 250; k < 270; k++) begin
`ifdef MA_ROUND_EN
            send(10'(k), 2'b01, 10'(k - 1), "n4_ramp");
`else
            send(10'(k), 2'b01, 10'(k - 2), "n4_ramp");
`endif
        end
        for (int k = 270; k < 290; k++) begin
`ifdef MA_ROUND_EN
            send(10'(k), 2'b10, 10'(k - 3), "n8_ramp");
`else
            send(10'(k), 2'b10, 10'(k - 4), "n8_ramp");
`endif
        end
        for (int k = 290; k < 310; k++) begin
`ifdef MA_ROUND_EN
            send(10'(k), 2'b11, 10'(k - 7), "n16_ramp");
`else
            send(10'(k), 2'b11, 10'(k - 8), "n16_ramp");
`endif
        end
        tick();
        check("ramp_end_stb", 16'(uio_out[1]), 16'd0);

        // full scale at N=16
        for (int i = 0; i < 16; i++) begin
            set_pins(10'd1023, 2'b11, 1'b1);
            tick();
        end
        set_pins(10'd0, 2'b11, 1'b0);
        check("fs_uo", 16'(uo_out), 16'h00FF);
        check("fs_uio", 16'(uio_out), 16'h0032);
        tick();
        check("fs_uio_idle", 16'(uio_out), 16'h0030);
        send(10'd0, 2'b11, 10'd959, "fs_drop");
        check("fs_drop_uo", 16'(uo_out), 16'h00BF);
        tick();

        // window switch without flush
        for (int i = 0; i < 16; i++) begin
            set_pins(10'd100, 2'b00, 1'b1);
            tick();
        end
        check("ws_fill", 16'(get_result()), 16'd100);
        set_pins(10'd0, 2'b00, 1'b0);
        tick();
`ifdef MA_ROUND_EN
        send(10'd0, 2'b11, 10'd94, "ws0");
        send(10'd0, 2'b11, 10'd88, "ws1");
`else
        send(10'd0, 2'b11, 10'd93, "ws0");
        send(10'd0, 2'b11, 10'd87, "ws1");
`endif
        send(10'd0, 2'b11, 10'd81, "ws2");
        send(10'd0, 2'b11, 10'd75, "ws3");
        tick();

        // strobe held 3 cycles with ena=1: newest two now 0,0
        set_pins(10'd40, 2'b00, 1'b1);
        tick();
        check("hold_r0", 16'(get_result()), 16'd20);
        check("hold_s0", 16'(uio_out[1]), 16'd1);
        tick();
        check("hold_r1", 16'(get_result()), 16'd40);
        check("hold_s1", 16'(uio_out[1]), 16'd1);
        tick();
        check("hold_r2", 16'(get_result()), 16'd40);
        check("hold_s2", 16'(uio_out[1]), 16'd1);
        set_pins(10'd40, 2'b00, 1'b0);
        tick();
        check("hold_off_s", 16'(uio_out[1]), 16'd0);

        // same with ena=0: nothing accepted
        ena = 1'b0;
        set_pins(10'd200, 2'b00, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ena0_res", 16'(get_result()), 16'd40);
            check("ena0_stb", 16'(uio_out[1]), 16'd0);
        end
        set_pins(10'd200, 2'b00, 1'b0);
        ena = 1'b1;
        tick();
        send(10'd200, 2'b00, 10'd120, "ena0_hist");
        tick();

        // asynchronous reset mid-stream
        rst_n = 1'b0;
        #1;
        check("arst_uo", 16'(uo_out), 16'h00);
        check("arst_uio", 16'(uio_out), 16'h00);
        tick();
        rst_n = 1'b1;
        tick();
`ifdef MA_ROUND_EN
        send(10'd10, 2'b01, 10'd3, "post_rst");
`else
        send(10'd10, 2'b01, 10'd2, "post_rst");
`endif
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
